multicycle_control: RTL and testbench

Control sequencer for the multi-cycle RV64I-subset datapath. Steps each instruction through fetch, decode, execute, memory and writeback. Drives the shared datapath resources each cycle: PC, instruction register, unified memory port, register file, ALU and the immediate data extractor's format select. Stalls on a memory-ready handshake and reports illegal opcodes and retired instructions.

---
 rtl/multicycle_control.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control.sv | 137 +++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV64I-subset control sequencer
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic [2:0] state,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       alu_src,
   output logic [1:0] alu_op,
   output logic [1:0] imm_sel,
   output logic       illegal,
   output logic       retire
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_BRANCH = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_NONE = 3'd0,
      C_R    = 3'd1,
      C_I    = 3'd2,
      C_LD   = 3'd3,
      C_SD   = 3'd4,
      C_BEQ  = 3'd5
   } class_t;

   state_t state_q, state_d;
   class_t class_q, class_d, dec_class;

   // Classify the live opcode; only meaningful while in DECODE
   always_comb begin
      dec_class = C_NONE;
      case (opcode)
         7'b0110011: dec_class = C_R;
         7'b0010011: dec_class = C_I;
         7'b0000011: dec_class = C_LD;
         7'b0100011: dec_class = C_SD;
         7'b1100011: dec_class = C_BEQ;
         default:    dec_class = C_NONE;
      endcase
   end

   // Next-state and class capture; the class is latched leaving DECODE so
   // later states ignore whatever the opcode input does afterwards
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            class_d = dec_class;
            case (dec_class)
               C_R, C_I, C_LD, C_SD: state_d = S_EXEC;
               C_BEQ:                state_d = S_BRANCH;
               default:              state_d = S_FETCH;
            endcase
         end
         S_EXEC: begin
            case (class_q)
               C_R, C_I:   state_d = S_WB;
               C_LD, C_SD: state_d = S_MEM;
               default:    state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_ready) state_d = (class_q == C_LD) ? S_WB : S_FETCH;
         end
         S_WB:     state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // State and class registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         class_q <= C_NONE;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
      end
   end

   assign state = state_q;

   // Datapath controls decoded from state and class; reset silences everything
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src       = 1'b0;
      alu_op        = 2'b00;
      imm_sel       = 2'b00;
      illegal       = 1'b0;
      retire        = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;
            end
            S_DECODE: begin
               case (dec_class)
                  C_SD:    imm_sel = 2'b01;
                  C_BEQ:   imm_sel = 2'b10;
                  default: imm_sel = 2'b00;
               endcase
               illegal = (dec_class == C_NONE);
            end
            S_EXEC: begin
               case (class_q)
                  C_R: alu_op = 2'b10;
                  C_I: begin
                     alu_src = 1'b1;
                     alu_op  = 2'b10;
                  end
                  C_LD: alu_src = 1'b1;
                  C_SD: begin
                     alu_src = 1'b1;
                     imm_sel = 2'b01;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               iord      = 1'b1;
               mem_read  = (class_q == C_LD);
               mem_write = (class_q == C_SD);
               retire    = mem_ready && (class_q == C_SD);
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (class_q == C_LD);
               retire     = 1'b1;
            end
            S_BRANCH: begin
               alu_op        = 2'b01;
               imm_sel       = 2'b10;
               pc_write_cond = 1'b1;
               retire        = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic       mem_ready;
   logic [2:0] state;
   logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
   logic       reg_write, mem_to_reg, alu_src, illegal, retire;
   logic [1:0] alu_op, imm_sel;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .state(state), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
      .alu_op(alu_op), .imm_sel(imm_sel), .illegal(illegal), .retire(retire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector bit masks
   localparam logic [14:0] MR    = 15'h4000;
   localparam logic [14:0] MW    = 15'h2000;
   localparam logic [14:0] IORD  = 15'h1000;
   localparam logic [14:0] IRW   = 15'h0800;
   localparam logic [14:0] PCW   = 15'h0400;
   localparam logic [14:0] PCC   = 15'h0200;
   localparam logic [14:0] RW    = 15'h0100;
   localparam logic [14:0] M2R   = 15'h0080;
   localparam logic [14:0] ASRC  = 15'h0040;
   localparam logic [14:0] A_SUB = 15'h0010;
   localparam logic [14:0] A_FN  = 15'h0020;
   localparam logic [14:0] I_S   = 15'h0004;
   localparam logic [14:0] I_SB  = 15'h0008;
   localparam logic [14:0] ILL   = 15'h0002;
   localparam logic [14:0] RET   = 15'h0001;
   localparam logic [14:0] NONE  = 15'h0000;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   typedef struct {
      string       tag;
      logic [2:0]  st;
      logic [14:0] outs;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [14:0] outs_now();
      return {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
              reg_write, mem_to_reg, alu_src, alu_op, imm_sel, illegal, retire};
   endfunction

   // Drive one cycle of inputs, queue the expectation, compare mid-cycle
   task automatic step(input string tag, input logic rst, input logic [6:0] op,
                       input logic rdy, input logic [2:0] st, input logic [14:0] outs);
      exp_t e;
      reset     = rst;
      opcode    = op;
      mem_ready = rdy;
      exp_q.push_back('{tag, st, outs});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      assert (state === e.st) else begin
         errors++;
         $error("FAIL %s state: observed %0d expected %0d", e.tag, state, e.st);
      end
      checks++;
      assert (outs_now() === e.outs) else begin
         errors++;
         $error("FAIL %s outs: observed %h expected %h", e.tag, outs_now(), e.outs);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      opcode    = OP_BAD;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step("reset",        1, OP_BAD, 1, 3'd0, NONE);
      step("post_reset",   0, OP_BAD, 1, 3'd0, MR | IRW | PCW);
      // R-type; opcode input is garbage after DECODE to prove class capture
      step("r_decode",     0, OP_R,   1, 3'd1, NONE);
      step("r_exec",       0, OP_BAD, 1, 3'd2, A_FN);
      step("r_wb",         0, OP_BAD, 1, 3'd4, RW | RET);
      // LD with a two-cycle MEM stall
      step("ld_fetch",     0, OP_BAD, 1, 3'd0, MR | IRW | PCW);
      step("ld_decode",    0, OP_LD,  1, 3'd1, NONE);
      step("ld_exec",      0, OP_BAD, 1, 3'd2, ASRC);
      step("ld_mem_st1",   0, OP_BAD, 0, 3'd3, MR | IORD);
      step("ld_mem_st2",   0, OP_BAD, 0, 3'd3, MR | IORD);
      step("ld_mem_done",  0, OP_BAD, 1, 3'd3, MR | IORD);
      step("ld_wb",        0, OP_BAD, 1, 3'd4, RW | M2R | RET);
      // SD with one FETCH stall
      step("sd_fetch_st",  0, OP_BAD, 0, 3'd0, MR);
      step("sd_fetch",     0, OP_BAD, 1, 3'd0, MR | IRW | PCW);
      step("sd_decode",    0, OP_SD,  1, 3'd1, I_S);
      step("sd_exec",      0, OP_BAD, 1, 3'd2, ASRC | I_S);
      step("sd_mem",       0, OP_BAD, 1, 3'd3, MW | IORD | RET);
      // BEQ
      step("beq_fetch",    0, OP_BAD, 1, 3'd0, MR | IRW | PCW);
      step("beq_decode",   0, OP_BEQ, 1, 3'd1, I_SB);
      step("beq_branch",   0, OP_BAD, 1, 3'd5, A_SUB | I_SB | PCC | RET);
      // Illegal opcode
      step("ill_fetch",    0, OP_BAD, 1, 3'd0, MR | IRW | PCW);
      step("ill_decode",   0, OP_BAD, 1, 3'd1, ILL);
      // Reset during SD MEM stall
      step("rs_fetch",     0, OP_BAD, 1, 3'd0, MR | IRW | PCW);
      step("rs_decode",    0, OP_SD,  1, 3'd1, I_S);
      step("rs_exec",      0, OP_BAD, 1, 3'd2, ASRC | I_S);
      step("rs_mem_st",    0, OP_BAD, 0, 3'd3, MW | IORD);
      step("rs_reset",     1, OP_BAD, 1, 3'd3, NONE);
      step("rs_after",     0, OP_BAD, 1, 3'd0, MR | IRW | PCW);
      // I-type after the abort
      step("i_decode",     0, OP_I,   1, 3'd1, NONE);
      step("i_exec",       0, OP_BAD, 1, 3'd2, ASRC | A_FN);
      step("i_wb",         0, OP_BAD, 1, 3'd4, RW | RET);
      step("i_next_fetch", 0, OP_BAD, 0, 3'd0, MR);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
